trace_checker: RTL and testbench
================================

# trace_checker

Write-back trace checker that sits on the consumer end of the core's `debug_wb_*` trace port. It buffers a golden reference stream (from the testbench or a trace ROM) in a small FIFO and pops one entry per committed register write. Each committed write is compared against the head entry. The checker keeps sticky pass/fail status, records the first mismatch and counts matches, so top-level FPGA and simulation harnesses can flag divergence without a software log.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: reference FIFO entries; power of two, at least 2.
- `END_PC`, 32'h1c000100: PC whose observation on `debug_wb_pc` ends the run.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `debug_wb_pc` in 32: write-back PC.
- `debug_wb_rf_we` in 4: byte write enables.
- `debug_wb_rf_wnum` in 5: destination register.
- `debug_wb_rf_wdata` in 32: write data.
- `ref_valid` in 1: reference entry offered.
- `ref_ready` out 1: checker accepts the entry.
- `ref_pc` in 32, `ref_wnum` in 5, `ref_wdata` in 32: reference entry fields.
- `done` out 1: state is PASS or FAIL.
- `pass` out 1: state is PASS.
- `err` out 1: sticky; set on the first mismatch.
- `underflow` out 1: sticky; set on a commit while the FIFO is empty.
- `err_pc` out 32, `err_exp_wdata` out 32, `err_got_wdata` out 32: first-mismatch record.
- `match_cnt` out 32: number of matching commits.

## Operation
- Commit event: `debug_wb_rf_we != 0` and `debug_wb_rf_wnum != 0`. Writes to r0 and cycles with all byte enables clear are ignored and do not pop the FIFO.
- FIFO push: `ref_valid & ref_ready`. `ref_ready = !full & (state == RUN)`. There is no push-while-full, even when a pop happens in the same cycle.
- Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
  - Empty: pointers are equal.
  - Full: indices are equal and the MSBs differ.
- Pop: every commit in RUN with the FIFO non-empty pops the head entry.
- Compare: `pc`, `wnum`, and `wdata` under a byte mask. Byte i of `wdata` is compared only when `debug_wb_rf_we[i]` is set.
- State machine: RUN (reset state), PASS, FAIL.
  - RUN to FAIL: a commit whose compare mismatches.
  - RUN to PASS: `debug_wb_pc == END_PC` in a cycle with no mismatching commit.
  - If both happen in the same cycle, FAIL wins.
  - PASS and FAIL hold until reset. No pops, pushes, compares or counter updates happen in either state.
- Mismatch capture, first mismatch only:
  - `err_pc` ← `debug_wb_pc`.
  - `err_exp_wdata` ← head `ref_wdata`.
  - `err_got_wdata` ← `debug_wb_rf_wdata`.
  - `err` ← 1.
- Underflow: a commit in RUN with the FIFO empty sets `underflow` and `err`, and moves to FAIL. In this case `err_exp_wdata` = 0 and `err_got_wdata`/`err_pc` are captured as usual.
- `match_cnt` increments by 1 per matching commit, saturating at 32'hffffffff.
- Reset mid-run clears:
  - the FIFO;
  - all sticky flags;
  - all capture registers;
  - the counter;
  - the state, which returns to RUN.

## Timing
- Reset values:
  - `done`, `pass`, `err`, `underflow` = 0.
  - `err_*` and `match_cnt` = 0.
  - `ref_ready` = 1 in the first cycle after reset deasserts. It is 0 while `reset` is high.
- Push to usable: an entry pushed at edge N can be popped by a commit sampled at edge N+1 or later.
- No bypass: a commit in the same cycle as a push into an empty FIFO is an underflow.
- Compare results are registered. Flags, counter, capture registers and state reflect a commit at edge N from just after edge N, i.e. visible in cycle N+1.
- Throughput: one commit per cycle and one push per cycle, concurrently.
- `done`/`pass` follow the registered state. The END_PC detection is visible one cycle after it is sampled.

## Test plan
- Push 3 entries (pc 0x1c000000/4/8, wnum 1/2/3, wdata 0x11/0x22/0x33), then commit the matching trace, then drive pc=END_PC → `match_cnt`=3, `pass`=1, `err`=0.
- Commit pc 0x1c000004 with wdata 0x23 against expected 0x22 → next cycle `err`=1, `err_pc`=0x1c000004, `err_exp_wdata`=0x22, `err_got_wdata`=0x23, `done`=1, `pass`=0. A later mismatch leaves the capture unchanged.
- Byte mask: expected 0xAABBCCDD, got 0x00BBCCDD with we=4'b0111 → match. Same data with we=4'b1111 → mismatch.
- Commits with wnum=0 or we=0 interleaved with real commits → no pops, `match_cnt` counts only the real commits, no error.
- Fill the FIFO to FIFO_DEPTH with no commits → `ref_ready`=0. Then one commit → `ref_ready`=1 next cycle. Commit with the FIFO empty → `underflow`=1, `err`=1, FAIL.
- Assert `reset` mid-run with 5 entries queued and `err`=1 → all outputs 0, `ref_ready`=1 after reset, and the first post-reset commit without a push underflows.

Source files
------------

// File: rtl/trace_checker.sv
// Write-back trace checker: compares committed register writes against a
// buffered golden reference stream and keeps sticky pass/fail status.
module trace_checker #(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] END_PC     = 32'h1c000100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] debug_wb_pc,
   input  logic [3:0]  debug_wb_rf_we,
   input  logic [4:0]  debug_wb_rf_wnum,
   input  logic [31:0] debug_wb_rf_wdata,
   input  logic        ref_valid,
   output logic        ref_ready,
   input  logic [31:0] ref_pc,
   input  logic [4:0]  ref_wnum,
   input  logic [31:0] ref_wdata,
   output logic        done,
   output logic        pass,
   output logic        err,
   output logic        underflow,
   output logic [31:0] err_pc,
   output logic [31:0] err_exp_wdata,
   output logic [31:0] err_got_wdata,
   output logic [31:0] match_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [1:0] ST_RUN  = 2'd0;
   localparam logic [1:0] ST_PASS = 2'd1;
   localparam logic [1:0] ST_FAIL = 2'd2;

   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [31:0] r_mem_pc    [FIFO_DEPTH];
   logic [4:0]  r_mem_wnum  [FIFO_DEPTH];
   logic [31:0] r_mem_wdata [FIFO_DEPTH];

   logic [AW:0] r_wptr;
   logic [AW:0] r_rptr;
   logic [1:0]  r_state;
   logic        r_err;
   logic        r_underflow;
   logic [31:0] r_err_pc;
   logic [31:0] r_err_exp;
   logic [31:0] r_err_got;
   logic [31:0] r_match_cnt;

   logic        w_empty;
   logic        w_full;
   logic        w_run;
   logic        w_commit;
   logic        w_chk;
   logic [31:0] w_head_pc;
   logic [4:0]  w_head_wnum;
   logic [31:0] w_head_wdata;
   logic [31:0] w_mask;
   logic        w_data_ne;
   logic        w_fields_ne;
   logic        w_mis;
   logic        w_hit;
   logic        w_uf;
   logic        w_pop;
   logic        w_push;
   logic        w_end;
   logic        w_cnt_max;
   logic [1:0]  w_state_nxt;

   // Pointer MSB distinguishes full from empty when the indices coincide.
   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) &&
                    (r_wptr[AW] != r_rptr[AW]);

   assign w_run    = (r_state == ST_RUN);
   assign w_commit = (|debug_wb_rf_we) && (debug_wb_rf_wnum != 5'd0);
   assign w_chk    = w_run & w_commit;

   assign w_head_pc    = r_mem_pc[r_rptr[AW-1:0]];
   assign w_head_wnum  = r_mem_wnum[r_rptr[AW-1:0]];
   assign w_head_wdata = r_mem_wdata[r_rptr[AW-1:0]];

   assign w_mask = {{8{debug_wb_rf_we[3]}},
                    {8{debug_wb_rf_we[2]}},
                    {8{debug_wb_rf_we[1]}},
                    {8{debug_wb_rf_we[0]}}};

   assign w_data_ne   = |((debug_wb_rf_wdata ^ w_head_wdata) & w_mask);
   assign w_fields_ne = (debug_wb_pc != w_head_pc) ||
                        (debug_wb_rf_wnum != w_head_wnum) ||
                        w_data_ne;

   assign w_uf  = w_chk & w_empty;
   assign w_mis = w_chk & (w_empty | w_fields_ne);
   assign w_hit = w_chk & ~w_empty & ~w_fields_ne;
   assign w_pop = w_chk & ~w_empty;

   assign ref_ready = ~reset & w_run & ~w_full;
   assign w_push    = ref_valid & ref_ready;

   assign w_end     = w_run & (debug_wb_pc == END_PC);
   assign w_cnt_max = &r_match_cnt;

   // A mismatch in the same cycle as END_PC still fails the run.
   always_comb begin
      w_state_nxt = r_state;
      if (w_mis) begin
         w_state_nxt = ST_FAIL;
      end else if (w_end) begin
         w_state_nxt = ST_PASS;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_pc[r_wptr[AW-1:0]]    <= ref_pc;
         r_mem_wnum[r_wptr[AW-1:0]]  <= ref_wnum;
         r_mem_wdata[r_wptr[AW-1:0]] <= ref_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_err       <= 1'b0;
         r_underflow <= 1'b0;
         r_err_pc    <= '0;
         r_err_exp   <= '0;
         r_err_got   <= '0;
      end else begin
         if (w_mis && !r_err) begin
            r_err     <= 1'b1;
            r_err_pc  <= debug_wb_pc;
            r_err_exp <= w_empty ? 32'd0 : w_head_wdata;
            r_err_got <= debug_wb_rf_wdata;
         end
         if (w_uf) begin
            r_underflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_match_cnt <= '0;
      end else if (w_hit && !w_cnt_max) begin
         r_match_cnt <= r_match_cnt + 32'd1;
      end
   end

   assign done          = (r_state == ST_PASS) || (r_state == ST_FAIL);
   assign pass          = (r_state == ST_PASS);
   assign err           = r_err;
   assign underflow     = r_underflow;
   assign err_pc        = r_err_pc;
   assign err_exp_wdata = r_err_exp;
   assign err_got_wdata = r_err_got;
   assign match_cnt     = r_match_cnt;

endmodule

// File: tb/tb_trace_checker.sv
// Bench for trace_checker: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_trace_checker;

   localparam int          DEPTH = 8;
   localparam logic [31:0] ENDPC = 32'h1c000100;
   localparam logic [31:0] BASE  = 32'h1c000000;

   logic        clk;
   logic        reset;
   logic [31:0] debug_wb_pc;
   logic [3:0]  debug_wb_rf_we;
   logic [4:0]  debug_wb_rf_wnum;
   logic [31:0] debug_wb_rf_wdata;
   logic        ref_valid;
   logic        ref_ready;
   logic [31:0] ref_pc;
   logic [4:0]  ref_wnum;
   logic [31:0] ref_wdata;
   logic        done;
   logic        pass;
   logic        err;
   logic        underflow;
   logic [31:0] err_pc;
   logic [31:0] err_exp_wdata;
   logic [31:0] err_got_wdata;
   logic [31:0] match_cnt;

   int total = 0;
   int bad   = 0;

   trace_checker #(.FIFO_DEPTH(DEPTH), .END_PC(ENDPC)) dut (
      .clk(clk),
      .reset(reset),
      .debug_wb_pc(debug_wb_pc),
      .debug_wb_rf_we(debug_wb_rf_we),
      .debug_wb_rf_wnum(debug_wb_rf_wnum),
      .debug_wb_rf_wdata(debug_wb_rf_wdata),
      .ref_valid(ref_valid),
      .ref_ready(ref_ready),
      .ref_pc(ref_pc),
      .ref_wnum(ref_wnum),
      .ref_wdata(ref_wdata),
      .done(done),
      .pass(pass),
      .err(err),
      .underflow(underflow),
      .err_pc(err_pc),
      .err_exp_wdata(err_exp_wdata),
      .err_got_wdata(err_got_wdata),
      .match_cnt(match_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  wnum;
      logic [31:0] wdata;
   } ent_t;

   // Reference model: queue of pending entries plus run status.
   ent_t        q[$];
   int          m_st;
   bit          m_err;
   bit          m_uf;
   logic [31:0] m_epc;
   logic [31:0] m_eexp;
   logic [31:0] m_egot;
   logic [31:0] m_cnt;

   logic [132:0] dut_snap;
   assign dut_snap = {ref_ready, done, pass, err, underflow, err_pc,
                      err_exp_wdata, err_got_wdata, match_cnt};

   function automatic bit m_ready();
      return (m_st == 0) && (q.size() < DEPTH);
   endfunction

   function automatic logic [132:0] m_snap();
      return {m_ready(), m_st != 0, m_st == 1, m_err, m_uf, m_epc,
              m_eexp, m_egot, m_cnt};
   endfunction

   function automatic void m_clear();
      q.delete();
      m_st = 0; m_err = 0; m_uf = 0;
      m_epc = 0; m_eexp = 0; m_egot = 0; m_cnt = 0;
   endfunction

   function automatic void m_update(logic [31:0] pc, logic [3:0] we,
                                    logic [4:0] wn, logic [31:0] wd,
                                    logic rv, ent_t re);
      bit   push;
      bit   mis;
      ent_t e;
      logic [31:0] exp;
      if (reset) begin
         m_clear();
         return;
      end
      if (m_st != 0) return;
      push = rv && m_ready();
      mis  = 0;
      exp  = 0;
      if (we != 0 && wn != 0) begin
         if (q.size() == 0) begin
            mis  = 1;
            m_uf = 1;
         end else begin
            e   = q.pop_front();
            exp = e.wdata;
            if (e.pc != pc || e.wnum != wn) mis = 1;
            for (int i = 0; i < 4; i++)
               if (we[i] && e.wdata[8*i +: 8] != wd[8*i +: 8]) mis = 1;
         end
         if (mis) begin
            if (!m_err) begin
               m_epc = pc; m_eexp = exp; m_egot = wd;
            end
            m_err = 1;
         end else if (m_cnt != 32'hffffffff) begin
            m_cnt = m_cnt + 1;
         end
      end
      if (push) q.push_back(re);
      if (mis) m_st = 2;
      else if (pc == ENDPC) m_st = 1;
   endfunction

   task automatic step(input logic [31:0] pc, input logic [3:0] we,
                       input logic [4:0] wn, input logic [31:0] wd,
                       input logic rv, input ent_t re);
      debug_wb_pc       = pc;
      debug_wb_rf_we    = we;
      debug_wb_rf_wnum  = wn;
      debug_wb_rf_wdata = wd;
      ref_valid = rv;
      ref_pc    = re.pc;
      ref_wnum  = re.wnum;
      ref_wdata = re.wdata;
      m_update(pc, we, wn, wd, rv, re);
      @(posedge clk);
      #1;
      ref_valid      = 1'b0;
      debug_wb_rf_we = 4'h0;
      debug_wb_pc    = 32'h0;
   endtask

   task automatic push(input ent_t e);
      step(32'h0, 4'h0, 5'd0, 32'h0, 1'b1, e);
   endtask

   task automatic commit(input logic [31:0] pc, input logic [3:0] we,
                         input logic [4:0] wn, input logic [31:0] wd);
      step(pc, we, wn, wd, 1'b0, '0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(32'h0, 4'h0, 5'd0, 32'h0, 1'b0, '0);
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(32'h0, 4'h0, 5'd0, 32'h0, 1'b1, '0);
      total++;
      if (ref_ready !== 1'b0) begin
         bad++;
         $display("FAIL rst_ready_hi: got %b want 0", ref_ready);
      end
      reset = 1'b0;
      #1;
      total++;
      if (dut_snap !== {1'b1, 132'd0}) begin
         bad++;
         $display("FAIL rst_state: got %h want %h", dut_snap,
                  {1'b1, 132'd0});
      end
   endtask

   task automatic test_basic();
      do_reset();
      for (int i = 0; i < 3; i++)
         push('{BASE + 32'(4*i), 5'(i+1), 32'(8'h11*(i+1))});
      for (int i = 0; i < 3; i++)
         commit(BASE + 32'(4*i), 4'hf, 5'(i+1), 32'(8'h11*(i+1)));
      commit(ENDPC, 4'h0, 5'd0, 32'h0);
      total++;
      if ({match_cnt, pass, done, err} !== {32'd3, 3'b110}) begin
         bad++;
         $display("FAIL basic_pass: got cnt=%0d p=%b d=%b e=%b want 3 1 1 0",
                  match_cnt, pass, done, err);
      end
      commit(BASE, 4'hf, 5'd1, 32'h11);
      total++;
      if ({pass, underflow, match_cnt} !== {2'b10, 32'd3}) begin
         bad++;
         $display("FAIL basic_hold: got p=%b u=%b cnt=%0d want 1 0 3",
                  pass, underflow, match_cnt);
      end
      total++;
      if (dut_snap !== m_snap()) begin
         bad++;
         $display("FAIL basic_model: got %h want %h", dut_snap, m_snap());
      end
   endtask

   task automatic test_mismatch();
      do_reset();
      push('{BASE, 5'd1, 32'h11});
      push('{BASE + 32'd4, 5'd2, 32'h22});
      push('{BASE + 32'd8, 5'd3, 32'h33});
      commit(BASE, 4'hf, 5'd1, 32'h11);
      commit(BASE + 32'd4, 4'hf, 5'd2, 32'h23);
      total++;
      if ({err, done, pass, err_pc, err_exp_wdata, err_got_wdata} !==
          {3'b110, BASE + 32'd4, 32'h22, 32'h23}) begin
         bad++;
         $display("FAIL mis_capture: got e=%b d=%b p=%b pc=%h exp=%h got=%h",
                  err, done, pass, err_pc, err_exp_wdata, err_got_wdata);
      end
      commit(BASE + 32'd8, 4'hf, 5'd3, 32'h99);
      total++;
      if ({err_pc, err_exp_wdata, err_got_wdata, match_cnt} !==
          {BASE + 32'd4, 32'h22, 32'h23, 32'd1}) begin
         bad++;
         $display("FAIL mis_sticky: got pc=%h exp=%h got=%h cnt=%0d",
                  err_pc, err_exp_wdata, err_got_wdata, match_cnt);
      end
   endtask

   task automatic test_mask();
      do_reset();
      push('{BASE, 5'd5, 32'hAABBCCDD});
      push('{BASE + 32'd4, 5'd5, 32'hAABBCCDD});
      commit(BASE, 4'b0111, 5'd5, 32'h00BBCCDD);
      total++;
      if ({err, match_cnt} !== {1'b0, 32'd1}) begin
         bad++;
         $display("FAIL mask_match: got e=%b cnt=%0d want 0 1",
                  err, match_cnt);
      end
      commit(BASE + 32'd4, 4'b1111, 5'd5, 32'h00BBCCDD);
      total++;
      if ({err, err_exp_wdata, err_got_wdata} !==
          {1'b1, 32'hAABBCCDD, 32'h00BBCCDD}) begin
         bad++;
         $display("FAIL mask_mis: got e=%b exp=%h got=%h",
                  err, err_exp_wdata, err_got_wdata);
      end
   endtask

   task automatic test_ignored();
      do_reset();
      push('{BASE, 5'd7, 32'h70});
      push('{BASE + 32'd4, 5'd8, 32'h80});
      commit(BASE + 32'd40, 4'hf, 5'd0, 32'hdead);
      commit(BASE, 4'hf, 5'd7, 32'h70);
      commit(BASE + 32'd44, 4'h0, 5'd3, 32'hbeef);
      commit(BASE + 32'd4, 4'hf, 5'd8, 32'h80);
      total++;
      if ({match_cnt, err, underflow, done} !== {32'd2, 3'b000}) begin
         bad++;
         $display("FAIL ignored: got cnt=%0d e=%b u=%b d=%b want 2 0 0 0",
                  match_cnt, err, underflow, done);
      end
   endtask

   task automatic test_full_underflow();
      ent_t e;
      do_reset();
      for (int i = 0; i < DEPTH; i++)
         push('{BASE + 32'(4*i), 5'(i+1), 32'(i*3+1)});
      total++;
      if (ref_ready !== 1'b0) begin
         bad++;
         $display("FAIL full_ready: got %b want 0", ref_ready);
      end
      e = '{BASE + 32'd200, 5'd9, 32'h9};
      step(BASE, 4'hf, 5'd1, 32'd1, 1'b1, e);
      total++;
      if ({ref_ready, match_cnt} !== {1'b1, 32'd1}) begin
         bad++;
         $display("FAIL full_pop: got rdy=%b cnt=%0d want 1 1",
                  ref_ready, match_cnt);
      end
      for (int i = 1; i < DEPTH; i++)
         commit(BASE + 32'(4*i), 4'hf, 5'(i+1), 32'(i*3+1));
      total++;
      if ({match_cnt, err} !== {32'(DEPTH), 1'b0}) begin
         bad++;
         $display("FAIL full_drain: got cnt=%0d e=%b", match_cnt, err);
      end
      commit(BASE + 32'd300, 4'hf, 5'd4, 32'h1234);
      total++;
      if ({underflow, err, done, pass, err_pc, err_exp_wdata,
           err_got_wdata} !==
          {4'b1110, BASE + 32'd300, 32'h0, 32'h1234}) begin
         bad++;
         $display("FAIL underflow: got u=%b e=%b d=%b p=%b pc=%h exp=%h got=%h",
                  underflow, err, done, pass, err_pc, err_exp_wdata,
                  err_got_wdata);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 6; i++)
         push('{BASE + 32'(4*i), 5'(i+1), 32'(i+100)});
      commit(BASE, 4'hf, 5'd1, 32'd5);
      total++;
      if (err !== 1'b1) begin
         bad++;
         $display("FAIL mid_err: got %b want 1", err);
      end
      do_reset();
      total++;
      if (dut_snap !== {1'b1, 132'd0}) begin
         bad++;
         $display("FAIL mid_reset: got %h want %h", dut_snap,
                  {1'b1, 132'd0});
      end
      commit(BASE + 32'd4, 4'hf, 5'd2, 32'd101);
      total++;
      if ({underflow, err, done} !== 3'b111) begin
         bad++;
         $display("FAIL mid_uf: got u=%b e=%b d=%b want 111",
                  underflow, err, done);
      end
   endtask

   task automatic test_random();
      ent_t        re;
      logic [31:0] pc;
      logic [31:0] wd;
      logic [3:0]  we;
      logic [4:0]  wn;
      int          r;
      int          bit_i;
      for (int round = 0; round < 6; round++) begin
         do_reset();
         for (int cyc = 0; cyc < 200; cyc++) begin
            re = '{BASE + 32'($urandom_range(0, 63) * 4),
                   5'($urandom_range(0, 31)), $urandom};
            pc = 32'h0; we = 4'h0; wn = 5'd0; wd = $urandom;
            r  = $urandom_range(0, 9);
            if (r < 2) begin
               if ($urandom_range(0, 299) == 0) pc = ENDPC;
            end else if (r < 4) begin
               pc = BASE + 32'($urandom_range(0, 63) * 4);
               if ($urandom_range(0, 1) == 0) begin
                  we = 4'($urandom_range(1, 15));
               end else begin
                  wn = 5'($urandom_range(1, 31));
               end
            end else if (q.size() > 0 || $urandom_range(0, 99) == 0) begin
               we = 4'($urandom_range(1, 15));
               if (q.size() > 0) begin
                  pc = q[0].pc;
                  wn = q[0].wnum;
                  for (int b = 0; b < 4; b++)
                     if (we[b]) wd[8*b +: 8] = q[0].wdata[8*b +: 8];
                  if (wn == 5'd0) wn = 5'd1;
               end else begin
                  pc = BASE;
                  wn = 5'd1;
               end
               if ($urandom_range(0, 59) == 0) begin
                  bit_i = 0;
                  for (int b = 3; b >= 0; b--) if (we[b]) bit_i = 8 * b;
                  wd[bit_i] = ~wd[bit_i];
               end
            end
            step(pc, we, wn, wd, 1'($urandom_range(0, 1)), re);
            total++;
            if (dut_snap !== m_snap()) begin
               bad++;
               $display("FAIL rand r%0d c%0d: got %h want %h",
                        round, cyc, dut_snap, m_snap());
            end
         end
      end
   endtask

   initial begin
      reset             = 1'b1;
      debug_wb_pc       = 32'h0;
      debug_wb_rf_we    = 4'h0;
      debug_wb_rf_wnum  = 5'd0;
      debug_wb_rf_wdata = 32'h0;
      ref_valid         = 1'b0;
      ref_pc            = 32'h0;
      ref_wnum          = 5'd0;
      ref_wdata         = 32'h0;
      m_clear();
      @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_mismatch();
      test_mask();
      test_ignored();
      test_full_underflow();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
